// File: rtl/frac_clk_monitor.sv
// frac_clk_monitor: measures a monitored (divided / fractional) clock in the
// reference clock domain. The monitored clock is synchronised and edge
// detected, then each period between consecutive rising edges is counted in
// reference cycles over a window of win_len periods. The block reports the sum
// of the periods, the shortest and longest period, and a timeout flag if a
// period counter saturates.
//
// Optional build macro: FRAC_MON_RANGE_CHK_EN adds per_lo/per_hi inputs and a
// range_err output that flags any measured period outside [per_lo, per_hi].
module frac_clk_monitor #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned WIN_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clk_mon,
    input  logic                   start,
    input  logic [WIN_W-1:0]       win_len,
`ifdef FRAC_MON_RANGE_CHK_EN
    input  logic [CNT_W-1:0]       per_lo,
    input  logic [CNT_W-1:0]       per_hi,
    output logic                   range_err,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [CNT_W+WIN_W-1:0] total_cyc,
    output logic [CNT_W-1:0]       min_per,
    output logic [CNT_W-1:0]       max_per
);

    localparam int unsigned TOT_W = CNT_W + WIN_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeas,
        StDone
    } state_e;

    state_e state_q;

    // Synchroniser and edge detector
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    // Measurement state
    logic [CNT_W-1:0] per_cnt_q;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] edge_cnt_q;
    logic [TOT_W-1:0] tot_acc_q;
    logic [CNT_W-1:0] min_acc_q;
    logic [CNT_W-1:0] max_acc_q;

    // Next-step values and decisions
    logic [WIN_W-1:0] win_eff;
    logic [WIN_W-1:0] edge_upd;
    logic [TOT_W-1:0] tot_upd;
    logic [CNT_W-1:0] min_upd;
    logic [CNT_W-1:0] max_upd;
    logic             start_acc;
    logic             counting;
    logic             meas_rise;
    logic             last_edge;
    logic             sat_hit;
    logic             finish;

    // Bring the monitored clock into the reference domain and keep one
    // delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_mon};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edge detect, accumulator update values and FSM step decisions.
    always_comb begin
        rise      = sync_q[SYNC_STAGES-1] & ~prev_q;

        win_eff   = win_len;
        if (win_len == '0) begin
            win_eff[0] = 1'b1;
        end

        edge_upd  = edge_cnt_q + 1'b1;
        tot_upd   = tot_acc_q + {{WIN_W{1'b0}}, per_cnt_q};
        min_upd   = (per_cnt_q < min_acc_q) ? per_cnt_q : min_acc_q;
        max_upd   = (per_cnt_q > max_acc_q) ? per_cnt_q : max_acc_q;

        start_acc = (state_q == StIdle) && start;
        counting  = (state_q == StArm) || (state_q == StMeas);
        meas_rise = (state_q == StMeas) && rise;
        last_edge = meas_rise && (edge_upd == win_q);
        // A rise on the saturating cycle still closes a valid period.
        sat_hit   = counting && !rise && (per_cnt_q == CNT_MAX);
        finish    = last_edge || sat_hit;
    end

    // Control FSM with registered busy/done/timeout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        busy    <= 1'b1;
                        timeout <= 1'b0;
                        state_q <= StArm;
                    end
                end
                StArm: begin
                    if (rise) begin
                        state_q <= StMeas;
                    end else if (sat_hit) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StMeas: begin
                    if (last_edge) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else if (sat_hit) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Period counter: free-runs while armed or measuring, reloads to 1 on
    // each rise and holds once saturated.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            per_cnt_q <= '0;
        end else if (start_acc) begin
            per_cnt_q <= '0;
        end else if (counting) begin
            if (rise) begin
                per_cnt_q <= CNT_ONE;
            end else if (per_cnt_q != CNT_MAX) begin
                per_cnt_q <= per_cnt_q + 1'b1;
            end
        end
    end

    // Window length latch and per-window accumulators.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_q      <= '0;
            edge_cnt_q <= '0;
            tot_acc_q  <= '0;
            min_acc_q  <= '0;
            max_acc_q  <= '0;
        end else if (start_acc) begin
            win_q      <= win_eff;
            edge_cnt_q <= '0;
            tot_acc_q  <= '0;
            min_acc_q  <= '1;
            max_acc_q  <= '0;
        end else if (meas_rise) begin
            edge_cnt_q <= edge_upd;
            tot_acc_q  <= tot_upd;
            min_acc_q  <= min_upd;
            max_acc_q  <= max_upd;
        end
    end

    // Result registers: cleared on an accepted start, loaded as the window
    // closes. On the closing rise the final period is folded in directly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            total_cyc <= '0;
            min_per   <= '0;
            max_per   <= '0;
        end else if (start_acc) begin
            total_cyc <= '0;
            min_per   <= '0;
            max_per   <= '0;
        end else if (finish) begin
            total_cyc <= meas_rise ? tot_upd : tot_acc_q;
            min_per   <= meas_rise ? min_upd : min_acc_q;
            max_per   <= meas_rise ? max_upd : max_acc_q;
        end
    end

`ifdef FRAC_MON_RANGE_CHK_EN
    logic [CNT_W-1:0] lo_q;
    logic [CNT_W-1:0] hi_q;
    logic             range_acc_q;
    logic             per_bad;

    // Out-of-range test on the period being closed by this rise.
    always_comb begin
        per_bad = (per_cnt_q < lo_q) || (per_cnt_q > hi_q);
    end

    // Limit latch, sticky range accumulator and registered range_err.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lo_q        <= '0;
            hi_q        <= '0;
            range_acc_q <= 1'b0;
            range_err   <= 1'b0;
        end else if (start_acc) begin
            lo_q        <= per_lo;
            hi_q        <= per_hi;
            range_acc_q <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            if (meas_rise && per_bad) begin
                range_acc_q <= 1'b1;
            end
            if (finish) begin
                range_err <= range_acc_q | (meas_rise & per_bad);
            end
        end
    end
`endif

endmodule

// File: tb/tb_frac_clk_monitor.sv
// Bench for frac_clk_monitor (CNT_W=8 build so the timeout path is short).
// The monitored clock is generated synchronously to clk with exact integer
// periods; expected results are queued when a run is started and compared
// when done pulses.
module tb_frac_clk_monitor;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned WIN_W       = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned TOT_W       = CNT_W + WIN_W;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             clk_mon;
    logic             start = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [TOT_W-1:0] total_cyc;
    logic [CNT_W-1:0] min_per;
    logic [CNT_W-1:0] max_per;
    logic             rerr_obs;

`ifdef FRAC_MON_RANGE_CHK_EN
    logic [CNT_W-1:0] per_lo = '0;
    logic [CNT_W-1:0] per_hi = '1;
    logic             range_err;
    assign rerr_obs = range_err;
`else
    assign rerr_obs = 1'b0;
`endif

    frac_clk_monitor #(
        .CNT_W      (CNT_W),
        .WIN_W      (WIN_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .clk_mon  (clk_mon),
        .start    (start),
        .win_len  (win_len),
`ifdef FRAC_MON_RANGE_CHK_EN
        .per_lo   (per_lo),
        .per_hi   (per_hi),
        .range_err(range_err),
`endif
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .total_cyc(total_cyc),
        .min_per  (min_per),
        .max_per  (max_per)
    );

    typedef struct packed {
        logic [TOT_W-1:0] total;
        logic [CNT_W-1:0] minp;
        logic [CNT_W-1:0] maxp;
        logic             tmo;
        logic             rerr;
    } res_t;

    res_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   mon_mode = 0;  // 0: held low, 1: period 3, 2: periods 4,5 alternating

    always #5 clk = ~clk;

    // Monitored clock: one-cycle high pulse at the start of each period.
    initial begin
        int ph;
        int plen;
        bit alt;
        ph = 0;
        plen = 3;
        alt = 1'b0;
        clk_mon = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (mon_mode == 0) begin
                clk_mon = 1'b0;
                ph = 0;
            end else begin
                if (ph == 0) plen = (mon_mode == 1) ? 3 : (alt ? 5 : 4);
                clk_mon = (ph == 0);
                ph++;
                if (ph >= plen) begin
                    ph = 0;
                    alt = ~alt;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic res_t observed();
        res_t r;
        r.total = total_cyc;
        r.minp  = min_per;
        r.maxp  = max_per;
        r.tmo   = timeout;
        r.rerr  = rerr_obs;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [WIN_W-1:0] wl);
        start   = 1'b1;
        win_len = wl;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < budget) begin
            tick();
            cyc++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    task automatic test_reset();
        res_t o;
        #2;
        o = observed();
        checks++;
        if (o !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got res=%h busy=%b done=%b, want all 0", o, busy, done);
        end
        #9;
        rstn = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_div3();
        bit seen;
        int cyc;
        int extra;
        res_t e;
        res_t o;
        mon_mode = 1;
        repeat (10) tick();
        sb_q.push_back('{total: 24, minp: 3, maxp: 3, tmo: 1'b0, rerr: 1'b0});
        pulse_start(8);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL div3_busy: got busy=%b, want 1", busy);
        end
        wait_done(200, seen, cyc);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL div3_done: no done within %0d cycles", cyc);
        end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL div3_sb: done with no expected result queued");
        end else begin
            e = sb_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL div3_result: got tot=%0d min=%0d max=%0d tmo=%b, want tot=%0d min=%0d max=%0d tmo=%b",
                         o.total, o.minp, o.maxp, o.tmo, e.total, e.minp, e.maxp, e.tmo);
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL div3_after: got busy=%b done=%b, want 0 0", busy, done);
        end
        count_done(30, extra);
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL div3_single_done: got %0d extra done pulses, want 0", extra);
        end
        o = observed();
        checks++;
        if (o.total !== 16'd24) begin
            errors++;
            $display("FAIL div3_hold: got total=%0d after done, want 24 held", o.total);
        end
    endtask

    task automatic test_frac();
        bit seen;
        int cyc;
        res_t e;
        res_t o;
        mon_mode = 2;
        repeat (12) tick();
        sb_q.push_back('{total: 45, minp: 4, maxp: 5, tmo: 1'b0, rerr: 1'b0});
        pulse_start(10);
        wait_done(300, seen, cyc);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL frac_done: no done within %0d cycles", cyc);
        end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL frac_sb: done with no expected result queued");
        end else begin
            e = sb_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL frac_result: got tot=%0d min=%0d max=%0d tmo=%b, want tot=%0d min=%0d max=%0d tmo=%b",
                         o.total, o.minp, o.maxp, o.tmo, e.total, e.minp, e.maxp, e.tmo);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        bit seen;
        int cyc;
        res_t e;
        res_t o;
        mon_mode = 0;
        repeat (10) tick();
        sb_q.push_back('{total: 0, minp: 8'hFF, maxp: 0, tmo: 1'b1, rerr: 1'b0});
        pulse_start(8);
        wait_done(600, seen, cyc);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout_done: no done within %0d cycles", cyc);
        end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL timeout_sb: done with no expected result queued");
        end else begin
            e = sb_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL timeout_result: got tot=%0d min=%0h max=%0d tmo=%b, want tot=%0d min=%0h max=%0d tmo=%b",
                         o.total, o.minp, o.maxp, o.tmo, e.total, e.minp, e.maxp, e.tmo);
            end
            checks++;
            if (cyc < 250 || cyc > 262) begin
                errors++;
                $display("FAIL timeout_latency: got done after %0d cycles, want about 256", cyc);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        bit seen;
        int cyc;
        int extra;
        res_t e;
        res_t o;
        mon_mode = 1;
        repeat (10) tick();
        sb_q.push_back('{total: 24, minp: 3, maxp: 3, tmo: 1'b0, rerr: 1'b0});
        pulse_start(8);
        repeat (5) tick();
        pulse_start(2);  // while busy: must be ignored
        wait_done(200, seen, cyc);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_done: no done within %0d cycles", cyc);
        end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_sb: done with no expected result queued");
        end else begin
            e = sb_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_result: got tot=%0d min=%0d max=%0d, want tot=%0d min=%0d max=%0d",
                         o.total, o.minp, o.maxp, e.total, e.minp, e.maxp);
            end
        end
        pulse_start(8);  // seen by the DUT while in DONE: ignored
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start_at_done: got busy=%b, want 0", busy);
        end
        count_done(40, extra);
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL b2b_ignored: got %0d done pulses from ignored starts, want 0", extra);
        end
        sb_q.push_back('{total: 3, minp: 3, maxp: 3, tmo: 1'b0, rerr: 1'b0});
        pulse_start(0);
        wait_done(100, seen, cyc);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL win0_done: no done within %0d cycles", cyc);
        end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL win0_sb: done with no expected result queued");
        end else begin
            e = sb_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL win0_result: got tot=%0d min=%0d max=%0d, want tot=%0d min=%0d max=%0d",
                         o.total, o.minp, o.maxp, e.total, e.minp, e.maxp);
            end
        end
        count_done(20, extra);
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL win0_single_done: got %0d extra done pulses, want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int cyc;
        int extra;
        res_t e;
        res_t o;
        mon_mode = 1;
        repeat (5) tick();
        pulse_start(8);  // aborted run: nothing queued
        repeat (12) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy: got busy=%b before abort, want 1", busy);
        end
        rstn = 1'b0;
        #1;
        o = observed();
        checks++;
        if (o !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear: got res=%h busy=%b done=%b, want all 0", o, busy, done);
        end
        repeat (3) tick();
        rstn = 1'b1;
        count_done(40, extra);
        checks++;
        if (extra != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_done: got %0d done pulses busy=%b, want 0 0", extra, busy);
        end
        sb_q.push_back('{total: 24, minp: 3, maxp: 3, tmo: 1'b0, rerr: 1'b0});
        pulse_start(8);
        wait_done(200, seen, cyc);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rstmid_rerun_done: no done within %0d cycles", cyc);
        end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL rstmid_sb: done with no expected result queued");
        end else begin
            e = sb_q.pop_front();
            o = observed();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rstmid_rerun: got tot=%0d min=%0d max=%0d tmo=%b, want tot=%0d min=%0d max=%0d tmo=%b",
                         o.total, o.minp, o.maxp, o.tmo, e.total, e.minp, e.maxp, e.tmo);
            end
        end
        repeat (3) tick();
    endtask

`ifdef FRAC_MON_RANGE_CHK_EN
    task automatic test_range();
        bit seen;
        int cyc;
        res_t e;
        res_t o;
        mon_mode = 2;
        repeat (10) tick();
        for (int k = 0; k < 2; k++) begin
            per_lo = 8'd4;
            per_hi = (k == 0) ? 8'd4 : 8'd5;
            sb_q.push_back('{total: 45, minp: 4, maxp: 5, tmo: 1'b0, rerr: (k == 0)});
            pulse_start(10);
            wait_done(300, seen, cyc);
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL range%0d_done: no done within %0d cycles", k, cyc);
            end else if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL range%0d_sb: done with no expected result queued", k);
            end else begin
                e = sb_q.pop_front();
                o = observed();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL range%0d_result: got tot=%0d min=%0d max=%0d rerr=%b, want tot=%0d min=%0d max=%0d rerr=%b",
                             k, o.total, o.minp, o.maxp, o.rerr, e.total, e.minp, e.maxp, e.rerr);
                end
            end
            repeat (3) tick();
        end
        per_lo = '0;
        per_hi = '1;
    endtask
`endif

    initial begin
        test_reset();
        test_div3();
        test_frac();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
`ifdef FRAC_MON_RANGE_CHK_EN
        test_range();
`endif
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d unmatched expected results, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frac_clk_monitor.md
Name: frac_clk_monitor

Overview:
- Measures a divided/fractional clock (e.g. output of a fractional divider) in the reference clock domain; the receiving end of the divider's clock output.
- Synchronises the monitored clock, detects rising edges, measures each period in reference-clock cycles over a programmable window of periods.
- Reports total, minimum and maximum period; used in-system and in benches to prove the divider's average ratio and jitter pattern.

Parameters:
CNT_W, 16, width of per-period counter and min/max results
WIN_W, 8, width of window length (number of periods measured)
SYNC_STAGES, 2, flops in monitored-clock synchroniser (>=2)

Ports:
clk  input  1  reference clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
clk_mon  input  1  monitored clock, asynchronous to clk
start  input  1  one-cycle pulse, begins measurement when idle
win_len  input  WIN_W  periods to measure, sampled on accepted start
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when results valid
timeout  output  1  result flag: a period counter saturated
total_cyc  output  CNT_W+WIN_W  sum of measured periods
min_per  output  CNT_W  shortest period in window
max_per  output  CNT_W  longest period in window

Behaviour:
- Reset (async, rstn=0): all outputs 0, FSM IDLE, synchroniser flops 0, internal counters 0.
- Sync: clk_mon through SYNC_STAGES flops, then one edge-detect flop; rise = sync & ~prev. Fixed detect latency SYNC_STAGES+1 cycles; does not alter measured periods.
- FSM: IDLE -> ARM -> MEAS -> DONE -> IDLE.
- IDLE: start=1 accepted; latch win_len (0 treated as 1); clear accumulators (total=0, min=all-ones, max=0, edge count=0); busy=1; go ARM. start in any other state ignored.
- ARM: wait for first rise; on rise clear period counter to 1, go MEAS. Period counter runs in ARM too; saturation -> timeout.
- MEAS: period counter increments each cycle. On rise: period = counter value; total += period; min = min(min, period); max = max(max, period); edge count +1; counter reloads to 1 (same cycle). When edge count reaches latched win_len on that rise -> DONE.
- Period counter saturates at 2^CNT_W-1; reaching it in ARM or MEAS -> timeout=1, go DONE; results reflect completed periods only (min stays all-ones if none).
- DONE: one cycle; done=1, busy=0 on next cycle; result outputs registered and held until next accepted start (timeout also cleared then). Return IDLE.
- total_cyc width CNT_W+WIN_W cannot overflow.
- Rise coinciding with saturation: rise wins, period recorded, no timeout.
- start in same cycle as done: ignored (FSM not yet IDLE).
- rstn low mid-measurement: immediate abort to reset values; no done.

Optional Feature:
- Macro FRAC_MON_RANGE_CHK_EN.
- Defined: extra inputs per_lo, per_hi (CNT_W each, sampled on accepted start) and output range_err (1 bit): set at DONE if any measured period < per_lo or > per_hi; cleared on next accepted start; reset 0.
- Not defined: ports absent, no range logic; other behaviour identical.

Test Plan:
- Reset released at 11 ns, clk 100 MHz, clk_mon = clk/3 steady, start with win_len=8 -> done once, total_cyc=24, min_per=3, max_per=3, timeout=0.
- clk_mon alternating periods 4,5 (divide-by-4.5), win_len=10 -> total_cyc=45, min_per=4, max_per=5.
- clk_mon held 0, CNT_W=8 build, start -> timeout=1, done after ~255 cycles, total_cyc=0, min_per=8'hFF, max_per=0.
- Second start pulse while busy, then win_len=0 run with clk/3 -> second pulse ignored; win_len=0 run gives total_cyc=3, single done.
- rstn asserted mid-MEAS -> outputs 0 immediately, no done; fresh start after release measures correctly.
- FRAC_MON_RANGE_CHK_EN, per_lo=4, per_hi=4, periods 4,5 pattern -> range_err=1; per_hi=5 -> range_err=0.
